// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Write-back scheduler and scoreboard in front of the single-write-port
// register file `regs`.
//  - Arbitrates the one write port among ALU / LSU / MDU write-back sources
//    with a round-robin pointer (last granted source).
//  - Keeps a pending bit per architectural register for issued instructions
//    whose results are still outstanding, and stalls issue on RAW / WAW.
// Ports:
//  clk, rst_n                   clock, asynchronous active-low reset
//  iss_val/rs1/rs2/*_use/rd/rd_wen   issue-stage instruction
//  iss_stall                    issue must hold this cycle
//  {alu,lsu,mdu}_wb_val/rd/dat  write-back requests (held until fired)
//  {alu,lsu,mdu}_wb_rdy         write-back accepted this cycle
//  wr_val/wr_rd/wr_dat          register-file write port (drives regs)
//  pend_vec                     scoreboard (bit 0 always 0)
//  wb_err                       sticky: write-back hit a non-pending register
module regfile_wb_sched #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_val,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   input  logic            iss_rs1_use,
   input  logic            iss_rs2_use,
   input  logic [4:0]      iss_rd,
   input  logic            iss_rd_wen,
   output logic            iss_stall,
   input  logic            alu_wb_val,
   input  logic [4:0]      alu_wb_rd,
   input  logic [XLEN-1:0] alu_wb_dat,
   output logic            alu_wb_rdy,
   input  logic            lsu_wb_val,
   input  logic [4:0]      lsu_wb_rd,
   input  logic [XLEN-1:0] lsu_wb_dat,
   output logic            lsu_wb_rdy,
   input  logic            mdu_wb_val,
   input  logic [4:0]      mdu_wb_rd,
   input  logic [XLEN-1:0] mdu_wb_dat,
   output logic            mdu_wb_rdy,
   output logic            wr_val,
   output logic [4:0]      wr_rd,
   output logic [XLEN-1:0] wr_dat,
   output logic [31:0]     pend_vec,
   output logic            wb_err
);

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSU = 2'd1;
   localparam logic [1:0] SRC_MDU = 2'd2;

   logic [1:0]      last_r;
   logic [31:0]     pend_r;
   logic            wb_err_r;

   logic [2:0]      val_s;
   logic [2:0]      pick_s;
   logic            fire_s;
   logic [1:0]      gnt_idx_s;
   logic [4:0]      wb_rd_s;
   logic [XLEN-1:0] wb_dat_s;
   logic            hazard_s;
   logic            iss_fire_s;
   logic [31:0]     set_s;
   logic [31:0]     clr_s;
   logic [31:0]     pend_nxt_s;
   logic            err_hit_s;

   // First valid source in the given priority order; returns {found, index}.
   function automatic logic [2:0] pick_first(input logic [2:0] v,
                                             input logic [1:0] p0,
                                             input logic [1:0] p1,
                                             input logic [1:0] p2);
      if (v[p0]) begin
         return {1'b1, p0};
      end else if (v[p1]) begin
         return {1'b1, p1};
      end else if (v[p2]) begin
         return {1'b1, p2};
      end else begin
         return 3'b000;
      end
   endfunction

   assign val_s = {mdu_wb_val, lsu_wb_val, alu_wb_val};

   // Round-robin: search starts at the source after the last granted one.
   always_comb begin
      pick_s = 3'b000;
      case (last_r)
         SRC_ALU: pick_s = pick_first(val_s, SRC_LSU, SRC_MDU, SRC_ALU);
         SRC_LSU: pick_s = pick_first(val_s, SRC_MDU, SRC_ALU, SRC_LSU);
         default: pick_s = pick_first(val_s, SRC_ALU, SRC_LSU, SRC_MDU);
      endcase
   end

   // A grant always goes to a valid source, so grant and fire coincide.
   assign fire_s    = pick_s[2];
   assign gnt_idx_s = pick_s[1:0];

   // Write-port mux; idle port presents zero index and data.
   always_comb begin
      wb_rd_s  = 5'd0;
      wb_dat_s = {XLEN{1'b0}};
      if (fire_s) begin
         case (gnt_idx_s)
            SRC_ALU: begin
               wb_rd_s  = alu_wb_rd;
               wb_dat_s = alu_wb_dat;
            end
            SRC_LSU: begin
               wb_rd_s  = lsu_wb_rd;
               wb_dat_s = lsu_wb_dat;
            end
            default: begin
               wb_rd_s  = mdu_wb_rd;
               wb_dat_s = mdu_wb_dat;
            end
         endcase
      end else begin
         wb_rd_s  = 5'd0;
         wb_dat_s = {XLEN{1'b0}};
      end
   end

   assign alu_wb_rdy = fire_s & (gnt_idx_s == SRC_ALU);
   assign lsu_wb_rdy = fire_s & (gnt_idx_s == SRC_LSU);
   assign mdu_wb_rdy = fire_s & (gnt_idx_s == SRC_MDU);
   assign wr_val     = fire_s;
   assign wr_rd      = wb_rd_s;
   assign wr_dat     = wb_dat_s;

   // A register written back this cycle is still pending: regs updates at the edge.
   assign hazard_s   = iss_val & ((iss_rs1_use & pend_r[iss_rs1]) |
                                  (iss_rs2_use & pend_r[iss_rs2]) |
                                  (iss_rd_wen  & pend_r[iss_rd]));
   assign iss_stall  = hazard_s;
   assign iss_fire_s = iss_val & ~hazard_s;

   // Scoreboard next state: set wins over clear on the same index; x0 never pends.
   always_comb begin
      set_s = 32'd0;
      clr_s = 32'd0;
      if (iss_fire_s && iss_rd_wen && (iss_rd != 5'd0)) begin
         set_s = 32'd1 << iss_rd;
      end else begin
         set_s = 32'd0;
      end
      if (fire_s && (wb_rd_s != 5'd0)) begin
         clr_s = 32'd1 << wb_rd_s;
      end else begin
         clr_s = 32'd0;
      end
      pend_nxt_s = ((pend_r & ~clr_s) | set_s) & ~32'd1;
   end

   assign err_hit_s = fire_s & (wb_rd_s != 5'd0) & ~pend_r[wb_rd_s];

   // State registers: pointer, scoreboard and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r   <= SRC_MDU;
         pend_r   <= 32'd0;
         wb_err_r <= 1'b0;
      end else begin
         if (fire_s) begin
            last_r <= gnt_idx_s;
         end else begin
            last_r <= last_r;
         end
         pend_r   <= pend_nxt_s;
         wb_err_r <= wb_err_r | err_hit_s;
      end
   end

   assign pend_vec = pend_r;
   assign wb_err   = wb_err_r;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that keeps the
// scoreboard as a bit array and the round-robin state as an integer.
module tb_regfile_wb_sched;

   logic        clk;
   logic        rst_n;
   logic        iss_val;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_rs1_use;
   logic        iss_rs2_use;
   logic [4:0]  iss_rd;
   logic        iss_rd_wen;
   logic        iss_stall;
   logic [2:0]  s_val;
   logic [4:0]  s_rd  [3];
   logic [31:0] s_dat [3];
   logic        alu_wb_rdy;
   logic        lsu_wb_rdy;
   logic        mdu_wb_rdy;
   logic        wr_val;
   logic [4:0]  wr_rd;
   logic [31:0] wr_dat;
   logic [31:0] pend_vec;
   logic        wb_err;

   int          n_checks;
   int          n_errors;

   // reference model state
   logic [31:0] m_pend;
   int          m_last;
   logic        m_err;
   int          last_g;
   logic        last_stall;
   logic [2:0]  hold;

   regfile_wb_sched #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_val(iss_val), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rs1_use(iss_rs1_use), .iss_rs2_use(iss_rs2_use),
      .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen), .iss_stall(iss_stall),
      .alu_wb_val(s_val[0]), .alu_wb_rd(s_rd[0]), .alu_wb_dat(s_dat[0]), .alu_wb_rdy(alu_wb_rdy),
      .lsu_wb_val(s_val[1]), .lsu_wb_rd(s_rd[1]), .lsu_wb_dat(s_dat[1]), .lsu_wb_rdy(lsu_wb_rdy),
      .mdu_wb_val(s_val[2]), .mdu_wb_rd(s_rd[2]), .mdu_wb_dat(s_dat[2]), .mdu_wb_rdy(mdu_wb_rdy),
      .wr_val(wr_val), .wr_rd(wr_rd), .wr_dat(wr_dat),
      .pend_vec(pend_vec), .wb_err(wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      iss_val = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      iss_rs1_use = 1'b0; iss_rs2_use = 1'b0; iss_rd = 5'd0; iss_rd_wen = 1'b0;
      s_val = 3'b000;
      for (int i = 0; i < 3; i++) begin
         s_rd[i] = 5'd0; s_dat[i] = 32'd0;
      end
      hold = 3'b000;
   endtask

   // Enter reset (from wherever), check reset state, release; ends 1ns after a posedge.
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      m_pend = 32'd0; m_last = 2; m_err = 1'b0;
      last_stall = 1'b0; last_g = -1;
      #2;
      check_eq("rst_pend", pend_vec, 32'd0);
      check_eq("rst_err", {31'd0, wb_err}, 32'd0);
      check_eq("rst_wrval", {31'd0, wr_val}, 32'd0);
      check_eq("rst_stall", {31'd0, iss_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One cycle: predict from the model, compare at negedge, advance model at posedge.
   task automatic run_cycle();
      int g;
      logic [2:0]  e_rdy;
      logic [4:0]  e_rd;
      logic [31:0] e_dat;
      logic        e_stall;
      @(negedge clk);
      g = -1;
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (m_last + k) % 3;
         if (g < 0 && s_val[idx]) g = idx;
      end
      e_rdy = 3'b000; e_rd = 5'd0; e_dat = 32'd0;
      if (g >= 0) begin
         e_rdy[g] = 1'b1; e_rd = s_rd[g]; e_dat = s_dat[g];
      end
      e_stall = iss_val && ((iss_rs1_use && m_pend[iss_rs1]) ||
                            (iss_rs2_use && m_pend[iss_rs2]) ||
                            (iss_rd_wen  && m_pend[iss_rd]));
      check_eq("rdy", {29'd0, mdu_wb_rdy, lsu_wb_rdy, alu_wb_rdy}, {29'd0, e_rdy});
      check_eq("wr_val", {31'd0, wr_val}, {31'd0, (g >= 0)});
      check_eq("wr_rd", {27'd0, wr_rd}, {27'd0, e_rd});
      check_eq("wr_dat", wr_dat, e_dat);
      check_eq("stall", {31'd0, iss_stall}, {31'd0, e_stall});
      check_eq("pend", pend_vec, m_pend);
      check_eq("wb_err", {31'd0, wb_err}, {31'd0, m_err});
      last_g = g;
      last_stall = e_stall;
      @(posedge clk);
      if (g >= 0) begin
         m_last = g;
         if (e_rd != 5'd0) begin
            if (!m_pend[e_rd]) m_err = 1'b1;
            m_pend[e_rd] = 1'b0;
         end
      end
      if (iss_val && !e_stall && iss_rd_wen && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic wen, input logic [4:0] rs1, input logic u1);
      iss_val = 1'b1; iss_rd = rd; iss_rd_wen = wen;
      iss_rs1 = rs1; iss_rs1_use = u1; iss_rs2 = 5'd0; iss_rs2_use = 1'b0;
   endtask

   function automatic logic [4:0] rand_rd();
      for (int t = 0; t < 4; t++) begin
         logic [4:0] r;
         r = 5'($urandom_range(1, 7));
         if (m_pend[r]) return r;
      end
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0;
      clear_inputs();
      do_reset();

      // wrap search: only MDU valid with last = MDU, then ALU beats LSU
      s_val[2] = 1'b1; s_rd[2] = 5'd0; s_dat[2] = 32'hDEAD_0002;
      run_cycle();
      s_val = 3'b011; s_rd[0] = 5'd0; s_dat[0] = 32'hA5A5_0000; s_rd[1] = 5'd0; s_dat[1] = 32'h1111_0001;
      run_cycle();
      s_val = 3'b000;
      // x0 destination: no pend bit, no stall, no error
      issue(5'd0, 1'b1, 5'd0, 1'b0);
      s_val[0] = 1'b1;
      run_cycle();
      check_eq("rd0_pend", pend_vec, 32'd0);
      check_eq("rd0_err", {31'd0, wb_err}, 32'd0);
      clear_inputs();

      // continuous triple request after reset: ALU,LSU,MDU,ALU with rd 1,2,3,1
      do_reset();
      for (int r = 1; r <= 3; r++) begin
         issue(5'(r), 1'b1, 5'd0, 1'b0);
         run_cycle();
      end
      iss_val = 1'b0;
      s_val = 3'b111;
      for (int i = 0; i < 3; i++) begin
         s_rd[i] = 5'(i + 1); s_dat[i] = 32'hC0DE_0000 + 32'(i);
      end
      for (int c = 0; c < 4; c++) run_cycle();
      check_eq("rr_err", {31'd0, wb_err}, 32'd1);
      check_eq("rr_pend", pend_vec, 32'd0);
      clear_inputs();

      // RAW on x5, released by LSU write-back
      issue(5'd5, 1'b1, 5'd0, 1'b0);
      run_cycle();
      issue(5'd0, 1'b0, 5'd5, 1'b1);
      for (int c = 0; c < 3; c++) run_cycle();
      s_val[1] = 1'b1; s_rd[1] = 5'd5; s_dat[1] = 32'h0000_0505;
      run_cycle();
      s_val[1] = 1'b0;
      check_eq("raw_release", {31'd0, iss_stall}, 32'd0);
      check_eq("raw_pend5", {31'd0, pend_vec[5]}, 32'd0);
      run_cycle();
      iss_val = 1'b0;

      // WAW on x7, released by MDU write-back, then re-marked by the issue
      issue(5'd7, 1'b1, 5'd0, 1'b0);
      run_cycle();
      for (int c = 0; c < 2; c++) run_cycle();
      s_val[2] = 1'b1; s_rd[2] = 5'd7; s_dat[2] = 32'h0000_0707;
      run_cycle();
      s_val[2] = 1'b0;
      check_eq("waw_release", {31'd0, iss_stall}, 32'd0);
      run_cycle();
      check_eq("waw_repend", {31'd0, pend_vec[7]}, 32'd1);
      clear_inputs();

      // asynchronous reset in the middle of a stall
      issue(5'd3, 1'b1, 5'd0, 1'b0); run_cycle();
      issue(5'd9, 1'b1, 5'd0, 1'b0); run_cycle();
      issue(5'd0, 1'b0, 5'd3, 1'b1); run_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pend", pend_vec, 32'd0);
      check_eq("mid_rst_stall", {31'd0, iss_stall}, 32'd0);
      do_reset();
      s_val = 3'b111;
      run_cycle();
      clear_inputs();

      // randomized traffic
      for (int it = 0; it < 2000; it++) begin
         if (it == 1000) begin
            #2;
            do_reset();
         end
         for (int i = 0; i < 3; i++) begin
            if (hold[i] && last_g == i) hold[i] = 1'b0;
            if (!hold[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  s_val[i] = 1'b1; s_rd[i] = rand_rd(); s_dat[i] = $urandom; hold[i] = 1'b1;
               end else begin
                  s_val[i] = 1'b0;
               end
            end
         end
         if (!(iss_val && last_stall)) begin
            iss_val     = ($urandom_range(0, 3) != 0);
            iss_rs1     = 5'($urandom_range(0, 7));
            iss_rs2     = 5'($urandom_range(0, 7));
            iss_rs1_use = 1'($urandom_range(0, 1));
            iss_rs2_use = 1'($urandom_range(0, 1));
            iss_rd      = 5'($urandom_range(0, 7));
            iss_rd_wen  = 1'($urandom_range(0, 1));
         end
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and scoreboard for the single-write-port `regs` register file. It arbitrates the one write port among three write-back sources (ALU, load/store unit, multiply/divide unit) with round-robin fairness. It also tracks the destination registers of all issued instructions whose results are still outstanding. From that it stalls the issue stage on RAW and WAW hazards. It sits between the execute units and `regs`; its write-port outputs drive `regs.rd_val/rd/rd_dat` directly.

## Interface
- XLEN, 32, data width of write-back data and of the register-file write port.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low; clock clk.
- iss_val  input  1  issue stage holds a valid instruction.
- iss_rs1 / iss_rs2  input  5 each  source register indices.
- iss_rs1_use / iss_rs2_use  input  1 each  instruction actually reads rs1 / rs2.
- iss_rd  input  5  destination register index.
- iss_rd_wen  input  1  instruction writes rd.
- iss_stall  output  1  issue must hold this cycle.
- alu_wb_val, lsu_wb_val, mdu_wb_val  input  1 each  source has a write-back pending.
- alu_wb_rd, lsu_wb_rd, mdu_wb_rd  input  5 each  write-back destination.
- alu_wb_dat, lsu_wb_dat, mdu_wb_dat  input  XLEN each  write-back data.
- alu_wb_rdy, lsu_wb_rdy, mdu_wb_rdy  output  1 each  write-back accepted this cycle.
- wr_val  output  1  register-file write enable.
- wr_rd  output  5  register-file write index.
- wr_dat  output  XLEN  register-file write data.
- pend_vec  output  32  scoreboard, one bit per register; bit 0 is constant 0.
- wb_err  output  1  sticky: a write-back targeted a non-pending register.

## Operation
- Source handshake:
  - A source fires when `*_wb_val & *_wb_rdy`.
  - A source holds `val/rd/dat` stable until it fires.
  - At most one `*_wb_rdy` is high per cycle.
  - `rdy` is asserted only to a source whose `val` is high.
- Round-robin arbitration:
  - 2-bit `last` pointer, encoded ALU=0, LSU=1, MDU=2.
  - Search order starts at the source after `last`, wrapping MDU→ALU.
  - The first valid source in that order is granted.
  - `last` updates to the granted source only on a fire; it is unchanged when no source is valid.
- Write port (combinational from the grant):
  - `wr_val` = any fire; `wr_rd/wr_dat` = granted source's rd/dat.
  - With no fire: `wr_rd` = 0 and `wr_dat` = 0.
  - A write-back with rd = 0 is accepted and drives `wr_val`; `regs` discards it. It does not touch the scoreboard or `wb_err`.
- Scoreboard hazard (combinational):
  - hazard = `iss_val & ((iss_rs1_use & pend[iss_rs1]) | (iss_rs2_use & pend[iss_rs2]) | (iss_rd_wen & pend[iss_rd]))`.
  - `iss_stall` = hazard.
- Issue fire = `iss_val & ~iss_stall`.
- Scoreboard update at the clock edge:
  - Issue fire with `iss_rd_wen` and `iss_rd ≠ 0` sets `pend[iss_rd]`.
  - A write-back fire with rd ≠ 0 clears `pend[rd]`.
  - Set and clear of the same index in the same cycle: set wins. This cannot occur legally because WAW stalls the issue, but the RTL must still resolve it this way.
- Because `regs` is read combinationally and written at the edge, a register written this cycle is still pending this cycle. Dependent issue therefore resumes the cycle after the write-back fire.
- `wb_err` is set on a write-back fire with rd ≠ 0 and `pend[rd]` = 0. It stays set until reset, and the write still occurs.

## Timing
- Reset values:
  - `pend_vec` = 0, `wb_err` = 0.
  - `last` = MDU, so ALU has first priority after reset.
  - All outputs low/zero, since no source can be valid-and-granted combinationally in reset.
- Write-back latency:
  - `val` → `rdy/wr_val` is 0 cycles (same cycle) when the source wins.
  - A losing source waits at most 2 cycles while the others keep requesting.
- Scoreboard update latency: 1 edge. An issue at cycle N makes a dependent stall from cycle N+1.
- Write-back at cycle M releases a dependent at cycle M+1.
- Reset mid-operation clears the scoreboard and pointer immediately (asynchronous). Sources are expected to drop `val` under the same reset.

## Test plan
- Reset, then `alu/lsu/mdu_wb_val` all high continuously with rd 1/2/3 pre-marked pending → grants ALU, LSU, MDU, ALU… one per cycle; `wr_rd` sequence 1,2,3,1; `pend` bits 1–3 cleared in order; `wb_err` rises at the 4th grant (rd 1 no longer pending).
- Issue writes x5 at cycle 0, next instruction reads rs1 = x5 → `iss_stall` = 1 cycles 1..M. LSU writes x5 at cycle M → stall drops at M+1; `pend[5]` = 0 at M+1.
- WAW: x7 pending, issue with `iss_rd` = 7 and no source use → `iss_stall` = 1 until x7 write-back fires, then issue sets `pend[7]` again.
- rd = 0 handling: issue with `iss_rd` = 0 and `iss_rd_wen` = 1 → no pend bit set, no stall. ALU write-back rd = 0 → `wr_val` = 1, `wb_err` stays 0.
- Only MDU valid with `last` = MDU → MDU granted same cycle (wrap search); `last` stays MDU.
- Assert rst_n low mid-stall with pend bits 3 and 9 set → `pend_vec` = 0 and `iss_stall` = 0 immediately; after release, ALU is granted first.
